// File: rtl/logic_result_fifo_if.sv
// Handshake bundle between a bitwise result producer, logic_result_fifo and its consumer.
// Optional head-word flags appear when RESULT_FLAGS_EN is defined.
interface logic_result_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
`ifdef RESULT_FLAGS_EN
  logic             out_zero;
  logic             out_ones;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, out_zero, out_ones
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, out_zero, out_ones
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
`endif
endinterface

// File: rtl/logic_result_fifo.sv
// First-word fall-through FIFO buffering bitwise-unit results; ready/valid on both sides.
// Define RESULT_FLAGS_EN to store per-entry zero/all-ones flags and expose them for the head word.
module logic_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  logic_result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             push_s;
  logic             pop_s;

  // Handshake qualifiers depend only on registered state, never on out_ready for in_ready.
  assign push_s = bus.in_valid & in_ready_r;
  assign pop_s  = out_valid_r & bus.out_ready;

  // Occupancy next-state from push/pop combination.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and registered status flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= CNT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s != CNT_FULL);
      out_valid_r <= (count_next_s != CNT_ZERO);
    end
  end

  // Data storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = mem_r[rd_ptr_r];
  assign bus.count     = count_r;

`ifdef RESULT_FLAGS_EN
  function automatic logic is_zero(input logic [WIDTH-1:0] d);
    return (d == {WIDTH{1'b0}});
  endfunction

  function automatic logic is_ones(input logic [WIDTH-1:0] d);
    return (&d);
  endfunction

  logic [DEPTH-1:0] zero_mem_r;
  logic [DEPTH-1:0] ones_mem_r;

  // Flags computed once at push time and stored beside the word.
  always_ff @(posedge clk) begin
    if (push_s) begin
      zero_mem_r[wr_ptr_r] <= is_zero(bus.in_data);
      ones_mem_r[wr_ptr_r] <= is_ones(bus.in_data);
    end
  end

  assign bus.out_zero = zero_mem_r[rd_ptr_r] & out_valid_r;
  assign bus.out_ones = ones_mem_r[rd_ptr_r] & out_valid_r;
`endif
endmodule

// File: tb/tb_logic_result_fifo.sv
// Directed, table-driven bench for logic_result_fifo plus hand-written multi-cycle sequences.
module tb_logic_result_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int NV    = 14;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  logic_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_cnt;
    logic        e_ir;
  } vec_t;

  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic e_ov, input logic [2:0] e_cnt,
                              input logic e_ir);
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, e_ov});
    check({tag, ".count"},     {29'd0, bus.count},     {29'd0, e_cnt});
    check({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, e_ir});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;

    // expected values hand-computed: {iv, din, ordy, e_ov, e_od, e_cnt, e_ir}
    tbl[0]  = '{1'b1, 32'h0000_129F, 1'b0, 1'b1, 32'h0000_129F, 3'd1, 1'b1};
    tbl[1]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 1'b1};
    tbl[2]  = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd1, 1'b1};
    tbl[3]  = '{1'b1, 32'hA849_2525, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd2, 1'b1};
    tbl[4]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd3, 1'b1};
    tbl[5]  = '{1'b1, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd4, 1'b0};
    tbl[6]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd4, 1'b0};
    tbl[7]  = '{1'b1, 32'h5555_5555, 1'b1, 1'b1, 32'hA849_2525, 3'd3, 1'b1};
    tbl[8]  = '{1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'hA849_2525, 3'd4, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 3'd3, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0001, 3'd2, 1'b1};
    tbl[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h5555_5555, 3'd1, 1'b1};
    tbl[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 1'b1};
    tbl[13] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 1'b1};

    // Reset state, before any clock edge
    #2;
    check_status("reset", 1'b0, 3'd0, 1'b1);
`ifdef RESULT_FLAGS_EN
    check("reset.out_zero", {31'd0, bus.out_zero}, 32'd0);
    check("reset.out_ones", {31'd0, bus.out_ones}, 32'd0);
`endif
    #6;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.in_valid  = tbl[i].iv;
      bus.in_data   = tbl[i].din;
      bus.out_ready = tbl[i].ordy;
      step();
      check_status($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_cnt, tbl[i].e_ir);
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d.out_data", i), bus.out_data, tbl[i].e_od);
`ifdef RESULT_FLAGS_EN
        check($sformatf("vec%0d.out_zero", i), {31'd0, bus.out_zero},
              {31'd0, tbl[i].e_od == 32'h0});
        check($sformatf("vec%0d.out_ones", i), {31'd0, bus.out_ones},
              {31'd0, tbl[i].e_od == 32'hFFFF_FFFF});
`endif
      end
    end

    // Asynchronous reset mid-operation with three words stored
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = 32'hAAAA_0000 + 32'(k);
      step();
    end
    bus.in_valid = 1'b0;
    check_status("pre_rst", 1'b1, 3'd3, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_status("async_rst", 1'b0, 3'd0, 1'b1);
    #2;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    step();
    bus.in_valid = 1'b0;
    check_status("post_rst", 1'b1, 3'd1, 1'b1);
    check("post_rst.out_data", bus.out_data, 32'h1234_5678);
    bus.out_ready = 1'b1;
    step();
    check_status("post_rst_drain", 1'b0, 3'd0, 1'b1);

    // Streaming: one word per cycle through pointer wrap
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_data = 32'hC0DE_0000 + 32'(k * 3);
      step();
      check($sformatf("stream%0d.count", k), {29'd0, bus.count}, 32'd1);
      check($sformatf("stream%0d.out_data", k), bus.out_data, 32'hC0DE_0000 + 32'(k * 3));
    end
    bus.in_valid = 1'b0;
    step();
    check_status("stream_end", 1'b0, 3'd0, 1'b1);

`ifdef RESULT_FLAGS_EN
    // Head flags follow the stored word
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_0000;
    step();
    bus.in_data   = 32'hFFFF_FFFF;
    step();
    bus.in_valid  = 1'b0;
    check("flags0.out_zero", {31'd0, bus.out_zero}, 32'd1);
    check("flags0.out_ones", {31'd0, bus.out_ones}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    check("flags1.out_zero", {31'd0, bus.out_zero}, 32'd0);
    check("flags1.out_ones", {31'd0, bus.out_ones}, 32'd1);
    step();
    check("flags2.out_zero", {31'd0, bus.out_zero}, 32'd0);
    check("flags2.out_ones", {31'd0, bus.out_ones}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
